// File: rtl/text_painter_if.sv
// Command and frame-buffer write port bundle for text_painter.
// A command transfers on a rising edge where cmd_valid && cmd_ready. cmd_ready depends only on state and reset, never on cmd_valid; the master holds cmd_* stable while cmd_valid is high and not yet accepted.
interface text_painter_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_x;
  logic [5:0]  cmd_y;
  logic [15:0] cmd_data;
  logic [5:0]  x;
  logic [5:0]  y;
  logic [4:0]  char;
  logic        we;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    input  cmd_ready, x, y, char, we, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    output cmd_ready, x, y, char, we, busy
  );
endinterface

// File: rtl/text_painter.sv
// Command-driven character painter: turns PUT_CHAR / PUT_NUM / CLEAR / FILL_ROW
// commands into single-cell frame-buffer writes, at most one per clock.
module text_painter #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int DIGIT_BASE = 1
) (
  input  logic           clk,
  input  logic           reset,
  text_painter_if.slave  bus,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_EMIT, S_CLEAR, S_ROW} state_t;

  localparam logic [1:0] OP_CHAR  = 2'b00;
  localparam logic [1:0] OP_NUM   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  localparam logic [6:0] COLS7    = 7'(COLS);
  localparam logic [6:0] ROWS7    = 7'(ROWS);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
  localparam logic [4:0] DIG_BASE = 5'(DIGIT_BASE);

  state_t      state, state_n;
  logic [5:0]  x_q, y_q, x_n, y_n;
  logic [4:0]  char_q, char_n;
  logic        we_q, we_n;
  logic [5:0]  px, py, px_n, py_n;
  logic [4:0]  pchar, pchar_n;
  logic [15:0] sh, sh_n;
  logic [19:0] bcd, bcd_n, bcd_adj;
  logic [3:0]  cnt, cnt_n;
  logic        nz, nz_n;
  logic [5:0]  cx, cy, cx_n, cy_n;
  logic        accept;
  logic [3:0]  dig;
  logic [6:0]  col;
  logic        blank;

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  function automatic logic [19:0] dd_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_at(input logic [19:0] b, input logic [2:0] i);
    case (i)
      3'd0:    return b[19:16];
      3'd1:    return b[15:12];
      3'd2:    return b[11:8];
      3'd3:    return b[7:4];
      default: return b[3:0];
    endcase
  endfunction

  assign bus.cmd_ready = (state == S_IDLE) && !reset;
  assign bus.busy      = (state != S_IDLE);
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.char      = char_q;
  assign bus.we        = we_q;
  assign dbg_state     = state;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) begin
      state  <= S_IDLE;
      x_q    <= '0;
      y_q    <= '0;
      char_q <= '0;
      we_q   <= 1'b0;
      px     <= '0;
      py     <= '0;
      pchar  <= '0;
      sh     <= '0;
      bcd    <= '0;
      cnt    <= '0;
      nz     <= 1'b0;
      cx     <= '0;
      cy     <= '0;
    end else begin
      state  <= state_n;
      x_q    <= x_n;
      y_q    <= y_n;
      char_q <= char_n;
      we_q   <= we_n;
      px     <= px_n;
      py     <= py_n;
      pchar  <= pchar_n;
      sh     <= sh_n;
      bcd    <= bcd_n;
      cnt    <= cnt_n;
      nz     <= nz_n;
      cx     <= cx_n;
      cy     <= cy_n;
    end
  end

  always_comb begin : next_state
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_NUM:   state_n = S_CONV;
            OP_CLEAR: state_n = S_CLEAR;
            OP_FILL:  state_n = ({1'b0, bus.cmd_y} < ROWS7) ? S_ROW : S_IDLE;
            default:  state_n = S_IDLE;
          endcase
        end
      end
      S_CONV:  if (cnt == 4'd15) state_n = S_EMIT;
      S_EMIT:  if (cnt == 4'd4) state_n = S_IDLE;
      S_CLEAR: if (cx == LAST_COL && cy == LAST_ROW) state_n = S_IDLE;
      S_ROW:   if (cx == LAST_COL) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin : output_comb
    x_n     = x_q;
    y_n     = y_q;
    char_n  = char_q;
    we_n    = 1'b0;
    px_n    = px;
    py_n    = py;
    pchar_n = pchar;
    sh_n    = sh;
    bcd_n   = bcd;
    cnt_n   = cnt;
    nz_n    = nz;
    cx_n    = cx;
    cy_n    = cy;
    bcd_adj = dd_adjust(bcd);
    dig     = digit_at(bcd, cnt[2:0]);
    col     = {1'b0, px} + {4'b0000, cnt[2:0]};
    // Leading zeros blank until the first non-zero digit; the units digit always shows.
    blank   = (dig == 4'd0) && !nz && (cnt != 4'd4);
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_CHAR: begin
              if ({1'b0, bus.cmd_x} < COLS7 && {1'b0, bus.cmd_y} < ROWS7) begin
                x_n    = bus.cmd_x;
                y_n    = bus.cmd_y;
                char_n = bus.cmd_data[4:0];
                we_n   = 1'b1;
              end
            end
            OP_NUM: begin
              px_n  = bus.cmd_x;
              py_n  = bus.cmd_y;
              sh_n  = bus.cmd_data;
              bcd_n = '0;
              cnt_n = '0;
              nz_n  = 1'b0;
            end
            OP_CLEAR: begin
              cx_n = '0;
              cy_n = '0;
            end
            default: begin
              cx_n    = '0;
              py_n    = bus.cmd_y;
              pchar_n = bus.cmd_data[4:0];
            end
          endcase
        end
      end
      S_CONV: begin
        bcd_n = {bcd_adj[18:0], sh[15]};
        sh_n  = {sh[14:0], 1'b0};
        cnt_n = (cnt == 4'd15) ? 4'd0 : cnt + 4'd1;
      end
      S_EMIT: begin
        nz_n  = nz || (dig != 4'd0);
        cnt_n = cnt + 4'd1;
        if (col < COLS7 && {1'b0, py} < ROWS7) begin
          x_n    = col[5:0];
          y_n    = py;
          char_n = blank ? 5'd0 : DIG_BASE + {1'b0, dig};
          we_n   = 1'b1;
        end
      end
      S_CLEAR: begin
        x_n    = cx;
        y_n    = cy;
        char_n = 5'd0;
        we_n   = 1'b1;
        if (cx == LAST_COL) begin
          cx_n = '0;
          cy_n = cy + 6'd1;
        end else begin
          cx_n = cx + 6'd1;
        end
      end
      S_ROW: begin
        x_n    = cx;
        y_n    = py;
        char_n = pchar;
        we_n   = 1'b1;
        cx_n   = cx + 6'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_text_painter.sv
// Bench for text_painter: directed vector table, hand sequences for multi-cycle
// corners, and random commands checked against a cell-level scoreboard model.
module tb_text_painter;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int DIGIT_BASE = 1;
  localparam logic [1:0] OP_CHAR = 2'b00, OP_NUM = 2'b01, OP_CLEAR = 2'b10, OP_FILL = 2'b11;

  typedef struct {
    logic [1:0] op;
    int x; int y; int data;
    int n_we; int n_busy; int first_we;
    int lx; int ly; int lc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] dbg_state;
  text_painter_if bus();

  text_painter #(.COLS(COLS), .ROWS(ROWS), .DIGIT_BASE(DIGIT_BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Scoreboard: every write the block makes must be the next expected cell.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (bus.busy != !bus.cmd_ready) begin
        errors++;
        $display("FAIL busy_vs_ready: busy=%0d ready=%0d", bus.busy, bus.cmd_ready);
      end
      if (bus.we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: x=%0d y=%0d char=%0d, want no write", bus.x, bus.y, bus.char);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if ({bus.x, bus.y, bus.char} != e) begin
            errors++;
            $display("FAIL write_data: got x=%0d y=%0d char=%0d, want x=%0d y=%0d char=%0d",
                     bus.x, bus.y, bus.char, e[16:11], e[10:5], e[4:0]);
          end
        end
      end
    end
  end

  // Reference model: lists the cells a command must write, in order.
  task automatic model_cmd(input logic [1:0] op, input int cx, input int cy, input int d,
                           output int n, output int nbusy);
    int p10[5];
    p10 = '{10000, 1000, 100, 10, 1};
    n = 0;
    nbusy = 0;
    case (op)
      OP_CHAR: if (cx < COLS && cy < ROWS) begin
        exp_q.push_back({6'(cx), 6'(cy), 5'(d % 32)});
        n = 1;
      end
      OP_NUM: begin
        nbusy = 21;
        for (int i = 0; i < 5; i++) begin
          int dg, code;
          dg = (d / p10[i]) % 10;
          code = (i < 4 && d < p10[i]) ? 0 : DIGIT_BASE + dg;
          if (cx + i < COLS && cy < ROWS) begin
            exp_q.push_back({6'(cx + i), 6'(cy), 5'(code)});
            n++;
          end
        end
      end
      OP_CLEAR: begin
        nbusy = COLS * ROWS;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            exp_q.push_back({6'(c), 6'(r), 5'd0});
            n++;
          end
      end
      default: if (cy < ROWS) begin
        nbusy = COLS;
        for (int c = 0; c < COLS; c++) begin
          exp_q.push_back({6'(c), 6'(cy), 5'(d % 32)});
          n++;
        end
      end
    endcase
  endtask

  task automatic drive_cmd(input logic [1:0] op, input int cx, input int cy, input int d);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x     = 6'(cx);
    bus.cmd_y     = 6'(cy);
    bus.cmd_data  = 16'(d);
  endtask

  // Issues one command and watches it until the block is idle again.
  task automatic run_cmd(input logic [1:0] op, input int cx, input int cy, input int d,
                         output int nwe, output int nbusy, output int first);
    int n;
    nwe = 0; nbusy = 0; first = 0; n = 0;
    @(negedge clk);
    check("ready_before_cmd", int'(bus.cmd_ready), 1);
    drive_cmd(op, cx, cy, d);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.we) begin
        nwe++;
        if (first == 0) first = n;
      end
      if (!bus.busy) break;
      nbusy++;
      if (n > 3000) begin
        check("cmd_timeout", n, 0);
        break;
      end
    end
  endtask

  vec_t vecs[13];
  int nwe, nbusy, first, mn, mbusy, seen_ready, wcount;

  initial begin
    vecs[0]  = '{OP_CHAR,  3,  4,     7,    1,    0,  1,  3,  4,  7};
    vecs[1]  = '{OP_CHAR,  39, 29,    31,   1,    0,  1,  39, 29, 31};
    vecs[2]  = '{OP_NUM,   10, 2,     65535, 5,   21, 18, 14, 2,  6};
    vecs[3]  = '{OP_NUM,   0,  0,     0,    5,    21, 18, 4,  0,  1};
    vecs[4]  = '{OP_NUM,   37, 3,     1234, 3,    21, 18, 39, 3,  3};
    vecs[5]  = '{OP_NUM,   36, 7,     42,   4,    21, 18, 39, 7,  5};
    vecs[6]  = '{OP_NUM,   63, 0,     9,    0,    21, 0,  0,  0,  0};
    vecs[7]  = '{OP_NUM,   0,  30,    5,    0,    21, 0,  0,  0,  0};
    vecs[8]  = '{OP_CHAR,  5,  30,    3,    0,    0,  0,  0,  0,  0};
    vecs[9]  = '{OP_CHAR,  40, 0,     3,    0,    0,  0,  0,  0,  0};
    vecs[10] = '{OP_FILL,  0,  31,    9,    0,    0,  0,  0,  0,  0};
    vecs[11] = '{OP_FILL,  0,  5,     9,    40,   40, 2,  39, 5,  9};
    vecs[12] = '{OP_CLEAR, 0,  0,     0,    1200, 1200, 2, 39, 29, 0};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_data = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_we", int'(bus.we), 0);
    check("reset_ready", int'(bus.cmd_ready), 0);
    check("reset_xyc", int'({bus.x, bus.y, bus.char}), 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", int'(bus.cmd_ready), 1);
    check("busy_after_reset", int'(bus.busy), 0);

    // Back-to-back PUT_CHAR with cmd_valid held.
    @(negedge clk);
    model_cmd(OP_CHAR, 3, 4, 7, mn, mbusy);
    model_cmd(OP_CHAR, 39, 29, 31, mn, mbusy);
    drive_cmd(OP_CHAR, 3, 4, 7);
    @(posedge clk);
    #1 drive_cmd(OP_CHAR, 39, 29, 31);
    @(negedge clk);
    check("b2b_first", int'({bus.we, bus.x, bus.y, bus.char}), int'({1'b1, 6'd3, 6'd4, 5'd7}));
    check("b2b_ready1", int'(bus.cmd_ready), 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_second", int'({bus.we, bus.x, bus.y, bus.char}), int'({1'b1, 6'd39, 6'd29, 5'd31}));
    check("b2b_ready2", int'(bus.cmd_ready), 1);
    @(negedge clk);
    check("b2b_idle_we", int'(bus.we), 0);

    for (int i = 0; i < 13; i++) begin
      model_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].data, mn, mbusy);
      run_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].data, nwe, nbusy, first);
      check($sformatf("vec%0d_we_count", i), nwe, vecs[i].n_we);
      check($sformatf("vec%0d_busy_cycles", i), nbusy, vecs[i].n_busy);
      check($sformatf("vec%0d_first_we", i), first, vecs[i].first_we);
      if (vecs[i].n_we > 0)
        check($sformatf("vec%0d_last_cell", i), int'({bus.x, bus.y, bus.char}),
              int'({6'(vecs[i].lx), 6'(vecs[i].ly), 5'(vecs[i].lc)}));
    end

    // FILL_ROW followed by a PUT_CHAR presented continuously: no write gap.
    model_cmd(OP_FILL, 0, 1, 2, mn, mbusy);
    model_cmd(OP_CHAR, 5, 6, 3, mn, mbusy);
    @(negedge clk);
    drive_cmd(OP_FILL, 0, 1, 2);
    @(posedge clk);
    #1 drive_cmd(OP_CHAR, 5, 6, 3);
    seen_ready = 0; wcount = 0;
    for (int n = 1; n <= 44; n++) begin
      @(negedge clk);
      if (seen_ready == 1) begin
        bus.cmd_valid = 1'b0;
        seen_ready = 2;
      end
      if (bus.cmd_ready && seen_ready == 0) seen_ready = 1;
      if (n >= 2 && n <= 42 && bus.we) wcount++;
      if (n == 43) check("chain_we_after", int'(bus.we), 0);
    end
    check("chain_we_no_gap", wcount, 41);

    // Randomized commands against the model.
    for (int i = 0; i < 40; i++) begin
      int r, cx, cy, d;
      logic [1:0] op;
      r = $urandom_range(0, 99);
      op = (r < 45) ? OP_CHAR : (r < 75) ? OP_NUM : (r < 97) ? OP_FILL : OP_CLEAR;
      cx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(30, 39);
      cy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, ROWS - 1);
      d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 65535);
      model_cmd(op, cx, cy, d, mn, mbusy);
      run_cmd(op, cx, cy, d, nwe, nbusy, first);
      check($sformatf("rand%0d_we_count", i), nwe, mn);
      check($sformatf("rand%0d_busy_cycles", i), nbusy, mbusy);
    end

    // Reset in the middle of a CLEAR.
    model_cmd(OP_CLEAR, 0, 0, 0, mn, mbusy);
    @(negedge clk);
    drive_cmd(OP_CLEAR, 0, 0, 0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (100) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_x", int'(bus.x), 0);
    check("midrst_y", int'(bus.y), 0);
    check("midrst_char", int'(bus.char), 0);
    check("midrst_we", int'(bus.we), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_ready", int'(bus.cmd_ready), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wcount = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.we || !bus.cmd_ready) wcount++;
    end
    check("postrst_quiet_ready", wcount, 0);
    model_cmd(OP_CHAR, 7, 8, 15, mn, mbusy);
    run_cmd(OP_CHAR, 7, 8, 15, nwe, nbusy, first);
    check("postrst_char_we", nwe, 1);
    check("postrst_char_cell", int'({bus.x, bus.y, bus.char}), int'({6'd7, 6'd8, 5'd15}));

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule

// File: doc/text_painter.md
# text_painter

Command-driven character painter that sits directly upstream of the VGA character frame buffer. It accepts one command at a time over a valid/ready handshake and turns it into a stream of single-cell writes on the frame buffer's write port (`x`, `y`, `char`, `we`), at most one write per clock. It supports single characters, right-aligned unsigned decimal numbers, row fills and full-screen clears, so software can update the display without addressing individual cells.

## Interface
- `COLS`, default 40: columns in the character grid.
- `ROWS`, default 30: rows in the character grid.
- `DIGIT_BASE`, default 1: character code for digit 0. Digit d is encoded as `DIGIT_BASE`+d. Code 0 is blank.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_op`  in  2  opcode: 00 PUT_CHAR, 01 PUT_NUM, 10 CLEAR, 11 FILL_ROW.
- `cmd_x`  in  6  target column.
- `cmd_y`  in  6  target row.
- `cmd_data`  in  16  PUT_CHAR/FILL_ROW use `cmd_data[4:0]` as the character code; PUT_NUM uses the full 16-bit unsigned value.
- `x`  out  6  write column, registered.
- `y`  out  6  write row, registered.
- `char`  out  5  write character code, registered.
- `we`  out  1  write strobe, registered, one-cycle pulse per cell.
- `busy`  out  1  a multi-cycle command is in progress.

## Operation
- **Handshake**
  - A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
  - `cmd_ready` = (state == IDLE) && !reset.
  - `busy` = (state != IDLE).
  - `cmd_*` inputs are sampled only at the accept edge. The block keeps its own copies.
- **States:** IDLE, CONV, EMIT, CLEAR, ROW.
- **PUT_CHAR**
  - Handled entirely in IDLE.
  - The accept edge registers `x`=`cmd_x`, `y`=`cmd_y`, `char`=`cmd_data[4:0]`, `we`=1.
  - State stays IDLE, so PUT_CHAR sustains one write per cycle.
  - If `cmd_x`>=`COLS` or `cmd_y`>=`ROWS`, the command is consumed and `we` stays 0.
- **PUT_NUM**
  - The accept edge loads the value and goes to CONV.
  - CONV runs a double-dabble conversion, one bit per cycle, for exactly 16 cycles, producing 5 BCD digits.
  - EMIT then runs for 5 cycles, writing the digits from most significant to least significant.
  - Digit i (0..4) is written at column `cmd_x`+i, row `cmd_y`.
  - Leading zeros are written as code 0 (blank). The least significant digit is never blanked.
  - A column >=`COLS` (7-bit compare) suppresses `we` for that slot only. The slot count is unchanged.
  - If `cmd_y`>=`ROWS`, all five writes are suppressed.
  - Return to IDLE after the 5th slot.
- **CLEAR**
  - Writes code 0 to all `COLS`×`ROWS` cells in row-major order: x runs 0..`COLS`-1, then y increments.
  - Starts at (0,0) and ends at (`COLS`-1, `ROWS`-1), one cell per cycle.
- **FILL_ROW**
  - Writes `cmd_data[4:0]` to columns 0..`COLS`-1 of row `cmd_y`.
  - If `cmd_y`>=`ROWS`, the block goes straight back to IDLE with no writes.
- **Outputs outside write cycles:** `we`=0. `x`/`y`/`char` hold their last values.
- **Reset**
  - All outputs clear asynchronously: `x`=0, `y`=0, `char`=0, `we`=0, `busy`=0, `cmd_ready`=0 while reset is asserted.
  - State returns to IDLE and any in-flight command is abandoned; no partial writes continue.
  - `cmd_ready`=1 on the first cycle after reset deasserts.

## Timing
Let A be the accept edge.

- **PUT_CHAR:** `we` is high in the cycle after A. `cmd_ready` never drops.
- **PUT_NUM**
  - CONV occupies edges A+1..A+16.
  - Write edges are A+17..A+21.
  - `cmd_ready` is low from A to A+21 and high after A+21.
  - Total occupancy: 22 cycles, including the accept cycle.
- **CLEAR**
  - The first write is registered at edge A+1; the last at edge A+1200.
  - `cmd_ready` is high after A+1200.
- **FILL_ROW**
  - Writes are registered at edges A+1..A+`COLS`.
  - `cmd_ready` is high after A+`COLS`.
- **`busy` vs. `cmd_ready`:** `busy` is the exact complement of `cmd_ready` outside reset.
- **Cross-command transitions**
  - The final write of a command and a new PUT_CHAR accepted in the next IDLE cycle do not overlap.
  - With continuous `cmd_valid`, writes are back-to-back with no gap, except for the 16 CONV cycles of PUT_NUM.
- **Downstream port:** the frame buffer captures on the same `clk`. Registered outputs guarantee `x`/`y`/`char` are stable whenever `we`=1.

## Test plan
- **Back-to-back PUT_CHAR:** PUT_CHAR (3,4,code 7) then (39,29,code 31) → `we`=1 for two consecutive cycles with (3,4,7) then (39,29,31). `cmd_ready` stays 1.
- **PUT_NUM full value:** PUT_NUM x=10,y=2,value 65535 → after 16 idle cycles, writes (10,2,7),(11,2,6),(12,2,6),(13,2,4),(14,2,6). `cmd_ready` returns after 22 cycles.
- **PUT_NUM zero and right-edge clipping:**
  - PUT_NUM value 0 at x=0,y=0 → codes 0,0,0,0,1.
  - value 1234 at x=37 → writes only at cols 37,38,39 with codes 0,2,3. The two remaining slots have `we`=0.
- **CLEAR sequence:** CLEAR → exactly 1200 `we` pulses, first (0,0), 40th (39,0), 41st (0,1), last (39,29), all `char`=0. `cmd_ready` returns the cycle after.
- **Out-of-range commands:**
  - PUT_CHAR y=30 → no `we`, `cmd_ready` stays 1.
  - FILL_ROW y=31 → no writes, `cmd_ready` back next cycle.
  - FILL_ROW y=5 code 9 → 40 writes on row 5.
- **Reset mid-command:** assert reset mid-CLEAR → all outputs 0 immediately. After deassert, no further writes, `cmd_ready`=1. A new PUT_CHAR works normally.
